dmem_arbiter: RTL and testbench

- Shares the single-port 8-bit data memory between two requesters.
  - The CPU datapath port (decoder/ALU side).
  - An I/O client port (button pulse capture and display refresh).
- The CPU has fixed priority. A bounded anti-starvation counter guarantees the I/O port a slot.
- Sits between the requesters and the data memory, which has synchronous read with 1-cycle latency.
- Emits per-requester grant and read-valid.

---
 rtl/dmem_arbiter_pkg.sv | 18 +
 rtl/dmem_arbiter_if.sv | 47 ++++
 rtl/dmem_arbiter_starve_counter.sv | 34 +++
 rtl/dmem_arbiter.sv | 98 +++++++++
 tb/tb_dmem_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: bus widths and read-owner encoding.
package dmem_arbiter_pkg;

  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 8;
  localparam int unsigned CntW = 4;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_IO   = 2'd2;

  typedef enum logic [1:0] {
    OwnNone = OWN_NONE,
    OwnCpu  = OWN_CPU,
    OwnIo   = OWN_IO
  } owner_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          io_req;
  logic          io_we;
  logic [AW-1:0] io_addr;
  logic [DW-1:0] io_wdata;
  logic          io_gnt;
  logic          io_rvalid;
  logic [DW-1:0] io_rdata;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  io_req, io_we, io_addr, io_wdata,
    output io_gnt, io_rvalid, io_rdata,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata
  );

  // Requester / memory side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output io_req, io_we, io_addr, io_wdata,
    input  io_gnt, io_rvalid, io_rdata,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata
  );

endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating counter of consecutive denied I/O cycles; hit_o flags that the limit is reached.
module dmem_arbiter_starve_counter
  import dmem_arbiter_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            inc_i,
  input  logic            clr_i,
  input  logic [CntW-1:0] max_i,
  output logic            hit_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q < max_i)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == max_i);

endmodule

// File: rtl/dmem_arbiter.sv
// Fixed-priority CPU/I-O arbiter for a single-port synchronous data memory with
// a bounded starvation guard for the I/O port and in-order 1-cycle read return.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input logic          clk_i,
  input logic          rst_ni,
  dmem_arbiter_if.slave bus
);

  localparam logic [CntW-1:0] StarveMaxW = CntW'(STARVE_MAX);

  logic   cpu_gnt, io_gnt, starve_hit;
  owner_e rd_owner_q, rd_owner_d;
  logic [DW-1:0] cpu_rdata_q, io_rdata_q;

  dmem_arbiter_starve_counter u_starve_counter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (bus.io_req & ~io_gnt),
    .clr_i  (io_gnt | ~bus.io_req),
    .max_i  (StarveMaxW),
    .hit_o  (starve_hit)
  );

  // Grants are gated by reset so nothing reaches memory while the block is held.
  always_comb begin
    cpu_gnt = 1'b0;
    io_gnt  = 1'b0;
    if (rst_ni) begin
      if (bus.cpu_req && bus.io_req) begin
        io_gnt  = starve_hit;
        cpu_gnt = ~starve_hit;
      end else begin
        cpu_gnt = bus.cpu_req;
        io_gnt  = bus.io_req;
      end
    end
  end

  always_comb begin
    bus.cpu_gnt = cpu_gnt;
    bus.io_gnt  = io_gnt;
    bus.m_en    = cpu_gnt | io_gnt;
    bus.m_we    = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    if (cpu_gnt) begin
      bus.m_we    = bus.cpu_we;
      bus.m_addr  = bus.cpu_addr;
      bus.m_wdata = bus.cpu_wdata;
    end else if (io_gnt) begin
      bus.m_we    = bus.io_we;
      bus.m_addr  = bus.io_addr;
      bus.m_wdata = bus.io_wdata;
    end
  end

  // Read-owner FSM: state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_owner_q <= OwnNone;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  // Read-owner FSM: next state follows this cycle's granted read, if any.
  always_comb begin
    rd_owner_d = OwnNone;
    if (cpu_gnt && !bus.cpu_we) begin
      rd_owner_d = OwnCpu;
    end else if (io_gnt && !bus.io_we) begin
      rd_owner_d = OwnIo;
    end
  end

  // Read-owner FSM: outputs. The non-owner keeps showing its last returned word.
  always_comb begin
    bus.cpu_rvalid = (rd_owner_q == OwnCpu);
    bus.io_rvalid  = (rd_owner_q == OwnIo);
    bus.cpu_rdata  = (rd_owner_q == OwnCpu) ? bus.m_rdata : cpu_rdata_q;
    bus.io_rdata   = (rd_owner_q == OwnIo)  ? bus.m_rdata : io_rdata_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cpu_rdata_q <= '0;
      io_rdata_q  <= '0;
    end else begin
      if (rd_owner_q == OwnCpu) cpu_rdata_q <= bus.m_rdata;
      if (rd_owner_q == OwnIo)  io_rdata_q  <= bus.m_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter with a queue-free behavioural model
// and a behavioural synchronous memory on the m_* port.
module tb_dmem_arbiter;

  localparam int unsigned StarveMax = 3;

  logic clk_i = 1'b0;
  logic rst_ni;

  dmem_arbiter_if bus();

  dmem_arbiter #(
    .STARVE_MAX (StarveMax)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] env_mem [256];
  logic [7:0] ref_mem [256];

  // Behavioural synchronous-read memory.
  always @(posedge clk_i) begin
    if (bus.m_en) begin
      if (bus.m_we) env_mem[bus.m_addr] = bus.m_wdata;
      else          bus.m_rdata <= env_mem[bus.m_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: denied-I/O streak, pending read (0 none, 1 cpu, 2 io) and its data.
  int         mdl_cnt   = 0;
  int         mdl_pend  = 0;
  logic [7:0] mdl_pdata = '0;
  logic [7:0] mdl_last_cpu = '0;
  logic [7:0] mdl_last_io  = '0;

  always @(negedge clk_i) begin
    logic       io_wins, cpu_wins, exp_we, exp_crv, exp_irv;
    logic [7:0] exp_addr, exp_wdata;
    #1;
    if (!rst_ni) begin
      chk("rst_ctl", {bus.cpu_gnt, bus.io_gnt, bus.m_en, bus.m_we, bus.cpu_rvalid, bus.io_rvalid},
          64'd0);
      chk("rst_data", {bus.m_addr, bus.m_wdata, bus.cpu_rdata, bus.io_rdata}, 64'd0);
      mdl_cnt = 0; mdl_pend = 0; mdl_last_cpu = '0; mdl_last_io = '0;
    end else begin
      io_wins  = bus.io_req && (!bus.cpu_req || mdl_cnt == int'(StarveMax));
      cpu_wins = bus.cpu_req && !io_wins;
      exp_we    = cpu_wins ? bus.cpu_we    : io_wins ? bus.io_we    : 1'b0;
      exp_addr  = cpu_wins ? bus.cpu_addr  : io_wins ? bus.io_addr  : 8'h00;
      exp_wdata = cpu_wins ? bus.cpu_wdata : io_wins ? bus.io_wdata : 8'h00;
      exp_crv = (mdl_pend == 1);
      exp_irv = (mdl_pend == 2);
      chk("grant", {bus.cpu_gnt, bus.io_gnt, bus.m_en, bus.m_we},
          {cpu_wins, io_wins, cpu_wins | io_wins, exp_we});
      chk("membus", {bus.m_addr, bus.m_wdata}, {exp_addr, exp_wdata});
      chk("rvalid", {bus.cpu_rvalid, bus.io_rvalid}, {exp_crv, exp_irv});
      chk("rdata", {bus.cpu_rdata, bus.io_rdata},
          {exp_crv ? mdl_pdata : mdl_last_cpu, exp_irv ? mdl_pdata : mdl_last_io});
      if (exp_crv) mdl_last_cpu = mdl_pdata;
      if (exp_irv) mdl_last_io  = mdl_pdata;
      if (bus.io_req && !io_wins) mdl_cnt = (mdl_cnt < int'(StarveMax)) ? mdl_cnt + 1 : mdl_cnt;
      else                        mdl_cnt = 0;
      mdl_pend = 0;
      if ((cpu_wins || io_wins) && exp_we) begin
        ref_mem[exp_addr] = exp_wdata;
      end else if (cpu_wins || io_wins) begin
        mdl_pend  = cpu_wins ? 1 : 2;
        mdl_pdata = ref_mem[exp_addr];
      end
    end
  end

  task automatic drive_cpu(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic drive_io(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d);
    bus.io_req = req; bus.io_we = we; bus.io_addr = a; bus.io_wdata = d;
  endtask

  initial begin
    logic cpu_seen, io_seen;
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      env_mem[i] = v;
      ref_mem[i] = v;
    end
    env_mem[8'h10] = 8'h5A; ref_mem[8'h10] = 8'h5A;
    env_mem[8'h01] = 8'h11; ref_mem[8'h01] = 8'h11;
    env_mem[8'h02] = 8'h22; ref_mem[8'h02] = 8'h22;

    rst_ni = 1'b1;
    drive_cpu(1'b1, 1'b0, 8'h00, 8'h00);
    drive_io(1'b0, 1'b0, 8'h00, 8'h00);
    #1 rst_ni = 1'b0;

    // Reset holds grants and strobes low even with a request present.
    repeat (2) @(negedge clk_i);
    #2 chk("rst_hold", {bus.cpu_gnt, bus.m_en, bus.cpu_rvalid, bus.io_rvalid}, 4'b0000);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #2 chk("rst_release_gnt", bus.cpu_gnt, 1'b1);

    // CPU read of 0x10.
    @(negedge clk_i);
    drive_cpu(1'b1, 1'b0, 8'h10, 8'h00);
    #2 chk("cpu_rd_bus", {bus.cpu_gnt, bus.m_en, bus.m_we, bus.m_addr}, {3'b110, 8'h10});
    @(negedge clk_i);
    drive_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    #2 chk("cpu_rd_ret", {bus.cpu_rvalid, bus.io_rvalid, bus.cpu_rdata}, {2'b10, 8'h5A});

    // Contention: I/O wins every fourth cycle.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      drive_cpu(1'b1, 1'b0, 8'(8'h20 + i), 8'h00);
      drive_io(1'b1, 1'b0, 8'(8'h30 + i), 8'h00);
      #2 chk($sformatf("contend_%0d", i), {bus.cpu_gnt, bus.io_gnt},
             (i % 4 == 3) ? 2'b01 : 2'b10);
    end
    @(negedge clk_i);
    drive_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    drive_io(1'b0, 1'b0, 8'h00, 8'h00);

    // I/O write to the top address.
    @(negedge clk_i);
    drive_io(1'b1, 1'b1, 8'hFF, 8'h3C);
    #2 chk("io_wr_bus", {bus.io_gnt, bus.m_we, bus.m_addr, bus.m_wdata}, {2'b11, 8'hFF, 8'h3C});
    @(negedge clk_i);
    drive_io(1'b0, 1'b0, 8'h00, 8'h00);
    #2 chk("io_wr_norv", {bus.cpu_rvalid, bus.io_rvalid}, 2'b00);

    // Alternating owners, back to back.
    @(negedge clk_i);
    drive_cpu(1'b1, 1'b0, 8'h01, 8'h00);
    @(negedge clk_i);
    drive_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    drive_io(1'b1, 1'b0, 8'h02, 8'h00);
    #2 chk("alt_cpu", {bus.cpu_rvalid, bus.io_rvalid, bus.cpu_rdata}, {2'b10, 8'h11});
    @(negedge clk_i);
    drive_io(1'b0, 1'b0, 8'h00, 8'h00);
    #2 chk("alt_io", {bus.cpu_rvalid, bus.io_rvalid, bus.io_rdata}, {2'b01, 8'h22});

    // Reset arriving while a read return is pending.
    @(negedge clk_i);
    drive_cpu(1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge clk_i);
    drive_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    rst_ni = 1'b0;
    #2 chk("midrd_drop", bus.cpu_rvalid, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #2 chk("midrd_rel", {bus.cpu_rvalid, bus.io_rvalid}, 2'b00);
    @(negedge clk_i);
    #2 chk("midrd_after", {bus.cpu_rvalid, bus.io_rvalid}, 2'b00);

    // Random traffic; requesters hold their fields until granted.
    cpu_seen = 1'b1;
    io_seen  = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i);
      rst_ni = ($urandom_range(0, 299) != 0);
      if (!bus.cpu_req || cpu_seen) begin
        drive_cpu($urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom_range(0, 15)),
                  8'($urandom));
      end
      if (!bus.io_req || io_seen) begin
        drive_io($urandom_range(0, 2) != 0, 1'($urandom), 8'($urandom_range(0, 15)),
                 8'($urandom));
      end
      #2;
      cpu_seen = bus.cpu_gnt;
      io_seen  = bus.io_gnt;
    end

    @(negedge clk_i);
    drive_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    drive_io(1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk_i);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
